calc_controller: RTL

//  Sequencing FSM for the keypad calculator: consumes one-cycle keycode strobes from the keypad

---
 rtl/calc_controller.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/calc_controller.sv
// Keypad calculator sequencer: builds two decimal operands from keycode
// strobes, runs add/sub/shift-add multiply and drives the displayed value.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ENTER_A    | collecting digits of the first operand
// OP_WAIT    | operator latched, waiting for the first digit of operand B
// ENTER_B    | collecting digits of the second operand
// COMPUTE    | arithmetic in progress; keys are dropped
// RESULT     | result shown; digit starts anew, operator chains on result
// ERROR      | overflow/underflow; only clear-all is honoured
module calc_controller #(
  parameter int WIDTH      = 10,
  parameter int MAX_VALUE  = 999,
  parameter int MAX_DIGITS = 3
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       keycode,
  output logic [WIDTH-1:0] display_value,
  output logic [1:0]       op_code,
  output logic             busy,
  output logic             error,
  output logic             key_dropped
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0]        MAX_D  = CW'(MAX_DIGITS);
  localparam logic [2*WIDTH-1:0]   MAX_V  = (2*WIDTH)'(MAX_VALUE);
  localparam logic [BW-1:0]        LAST_B = BW'(WIDTH - 1);

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] OP_MUL  = 2'd3;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_CA  = 4'hD;
  localparam logic [3:0] KEY_CE  = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  typedef enum logic [2:0] {
    ST_ENTER_A, ST_OP_WAIT, ST_ENTER_B, ST_COMPUTE, ST_RESULT, ST_ERROR
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_a, r_b, r_display;
  logic [CW-1:0]        r_cnt_a, r_cnt_b;
  logic [1:0]           r_op, r_next_op;
  logic                 r_busy, r_error, r_key_dropped;
  logic [2*WIDTH-1:0]   r_acc, r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [BW-1:0]        r_bit_cnt;

  logic                 w_is_digit;
  logic [WIDTH-1:0]     w_digit, w_a_next, w_b_next, w_sub;
  logic [WIDTH:0]       w_add;
  logic [2*WIDTH-1:0]   w_mul_acc, w_result;
  logic                 w_done, w_err;
  logic [1:0]           w_key_op;

  assign w_is_digit = (keycode <= 4'd9);
  assign w_digit    = {{(WIDTH-4){1'b0}}, keycode};
  // X*10 + d without a multiplier
  assign w_a_next   = (r_a << 3) + (r_a << 1) + w_digit;
  assign w_b_next   = (r_b << 3) + (r_b << 1) + w_digit;
  assign w_add      = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub      = r_a - r_b;
  assign w_mul_acc  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_done     = (r_op != OP_MUL) || (r_bit_cnt == '0);

  // Operator key to op code; non-operator keys map to none
  always_comb begin
    w_key_op = OP_NONE;
    case (keycode)
      KEY_ADD: w_key_op = OP_ADD;
      KEY_SUB: w_key_op = OP_SUB;
      KEY_MUL: w_key_op = OP_MUL;
      default: w_key_op = OP_NONE;
    endcase
  end

  // Final result of the pending operation and its error condition
  always_comb begin
    w_result = '0;
    case (r_op)
      OP_ADD:  w_result = {{(WIDTH-1){1'b0}}, w_add};
      OP_SUB:  w_result = {{WIDTH{1'b0}}, w_sub};
      OP_MUL:  w_result = w_mul_acc;
      default: w_result = '0;
    endcase
    w_err = (w_result > MAX_V) || ((r_op == OP_SUB) && (r_b > r_a));
  end

  // Sequencing FSM with registered outputs
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_ENTER_A;
      r_a <= '0; r_b <= '0; r_display <= '0;
      r_cnt_a <= '0; r_cnt_b <= '0;
      r_op <= OP_NONE; r_next_op <= OP_NONE;
      r_busy <= 1'b0; r_error <= 1'b0; r_key_dropped <= 1'b0;
      r_acc <= '0; r_mcand <= '0; r_mplier <= '0; r_bit_cnt <= '0;
    end else begin
      r_key_dropped <= 1'b0;
      if (r_state == ST_COMPUTE) begin
        if (key_valid) r_key_dropped <= 1'b1;
        if (r_op == OP_MUL) begin
          r_acc     <= w_mul_acc;
          r_mcand   <= r_mcand << 1;
          r_mplier  <= r_mplier >> 1;
          r_bit_cnt <= r_bit_cnt - 1'b1;
        end
        if (w_done) begin
          r_busy <= 1'b0;
          if (w_err) begin
            r_state   <= ST_ERROR;
            r_error   <= 1'b1;
            r_display <= '0;
            r_op      <= OP_NONE;
            r_next_op <= OP_NONE;
          end else begin
            r_a       <= w_result[WIDTH-1:0];
            r_display <= w_result[WIDTH-1:0];
            r_b       <= '0;
            r_cnt_b   <= '0;
            r_op      <= r_next_op;
            r_next_op <= OP_NONE;
            r_state   <= (r_next_op != OP_NONE) ? ST_OP_WAIT : ST_RESULT;
          end
        end
      end else if (key_valid) begin
        if (keycode == KEY_CA) begin
          r_state <= ST_ENTER_A;
          r_a <= '0; r_b <= '0; r_display <= '0;
          r_cnt_a <= '0; r_cnt_b <= '0;
          r_op <= OP_NONE; r_next_op <= OP_NONE;
          r_error <= 1'b0;
        end else begin
          case (r_state)
            ST_ENTER_A: begin
              if (w_is_digit) begin
                if (r_cnt_a < MAX_D) begin
                  r_a       <= w_a_next;
                  r_display <= w_a_next;
                  r_cnt_a   <= r_cnt_a + 1'b1;
                end
              end else if (w_key_op != OP_NONE) begin
                r_op    <= w_key_op;
                r_state <= ST_OP_WAIT;
              end else if (keycode == KEY_CE) begin
                r_a <= '0; r_cnt_a <= '0; r_display <= '0;
              end
            end
            ST_OP_WAIT: begin
              if (w_is_digit) begin
                r_b       <= w_digit;
                r_display <= w_digit;
                r_cnt_b   <= CW'(1);
                r_state   <= ST_ENTER_B;
              end else if (w_key_op != OP_NONE) begin
                r_op <= w_key_op;
              end
            end
            ST_ENTER_B: begin
              if (w_is_digit) begin
                if (r_cnt_b < MAX_D) begin
                  r_b       <= w_b_next;
                  r_display <= w_b_next;
                  r_cnt_b   <= r_cnt_b + 1'b1;
                end
              end else if (keycode == KEY_CE) begin
                r_b <= '0; r_cnt_b <= '0; r_display <= '0;
              end else if ((w_key_op != OP_NONE) || (keycode == KEY_EQ)) begin
                // w_key_op is none for equals, which ends the chain
                r_next_op <= w_key_op;
                r_state   <= ST_COMPUTE;
                r_busy    <= 1'b1;
                r_acc     <= '0;
                r_mcand   <= {{WIDTH{1'b0}}, r_a};
                r_mplier  <= r_b;
                r_bit_cnt <= LAST_B;
              end
            end
            ST_RESULT: begin
              if (w_is_digit) begin
                r_a       <= w_digit;
                r_display <= w_digit;
                r_cnt_a   <= CW'(1);
                r_op      <= OP_NONE;
                r_state   <= ST_ENTER_A;
              end else if (w_key_op != OP_NONE) begin
                r_op    <= w_key_op;
                r_state <= ST_OP_WAIT;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign display_value = r_display;
  assign op_code       = r_op;
  assign busy          = r_busy;
  assign error         = r_error;
  assign key_dropped   = r_key_dropped;

endmodule
